dmem_arbiter: RTL and testbench

Shares the single-port data memory between the pipeline MEM stage, driven from the EX/MEM register outputs, and an external host/DMA port used to load and unload packet buffers. The CPU has priority. A saturating starvation counter guarantees host forward progress by stalling the pipeline for one cycle when the host has waited too long. The block also tags each read so the one-cycle-latency memory data returns to the right requester, and it counts CPU stall cycles for performance monitoring.

---
 rtl/dmem_arbiter_pkg.sv | 13 +
 rtl/dmem_arbiter_sat_counter.sv | 35 +++
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter and its clients.
// Read-response ownership tag and the default data-memory address width.
package dmem_arbiter_pkg;

    localparam int unsigned DMEM_ADDR_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } rsp_owner_e;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Stops at MAX_VAL, which defaults to all-ones.
module sat_counter #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != MAX_VAL)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: MEM-stage CPU has priority, host/DMA port
// gets a forced grant after HOST_STARVE_MAX lost cycles. Reads are tagged for return.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned PROC_DATA_WIDTH = 16,
    parameter int unsigned DMEM_ADDR_WIDTH = DMEM_ADDR_WIDTH_DEF,
    parameter int unsigned HOST_STARVE_MAX = 4,
    parameter int unsigned STALL_CNT_WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cpu_mem_read_en_i,
    input  logic                       cpu_mem_write_en_i,
    input  logic [DMEM_ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [PROC_DATA_WIDTH-1:0] cpu_wdata_i,
    output logic                       cpu_stall_o,
    output logic [PROC_DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                       cpu_rvalid_o,
    input  logic                       host_req_i,
    input  logic                       host_we_i,
    input  logic [DMEM_ADDR_WIDTH-1:0] host_addr_i,
    input  logic [PROC_DATA_WIDTH-1:0] host_wdata_i,
    output logic                       host_gnt_o,
    output logic [PROC_DATA_WIDTH-1:0] host_rdata_o,
    output logic                       host_rvalid_o,
    output logic                       mem_en_o,
    output logic                       mem_we_o,
    output logic [DMEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [PROC_DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [PROC_DATA_WIDTH-1:0] mem_rdata_i,
    output logic [STALL_CNT_WIDTH-1:0] stall_count_o
);

    localparam int unsigned           STARVE_W   = $clog2(HOST_STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0]   STARVE_MAX = STARVE_W'(HOST_STARVE_MAX);

    logic                cpu_acc;
    logic                host_force;
    logic                cpu_win;
    logic                host_win;
    logic                stall_raw;
    logic [STARVE_W-1:0] starve_cnt;
    rsp_owner_e          rsp_owner_q, rsp_owner_d;

    assign cpu_acc    = cpu_mem_read_en_i | cpu_mem_write_en_i;
    assign host_force = host_req_i & (starve_cnt == STARVE_MAX);
    assign cpu_win    = cpu_acc & ~host_force;
    assign host_win   = host_req_i & (~cpu_acc | host_force);
    assign stall_raw  = host_win & cpu_acc;

    // Read-and-write together is treated as a store, so only a pure load is tagged.
    always_comb begin
        rsp_owner_d = OWN_NONE;
        if (host_win && !host_we_i) begin
            rsp_owner_d = OWN_HOST;
        end else if (cpu_win && !cpu_mem_write_en_i) begin
            rsp_owner_d = OWN_CPU;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_owner_q <= OWN_NONE;
        end else begin
            rsp_owner_q <= rsp_owner_d;
        end
    end

    // Combinational outputs are held at zero while reset is asserted.
    always_comb begin
        mem_en_o     = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        host_gnt_o   = 1'b0;
        cpu_stall_o  = 1'b0;
        cpu_rdata_o  = '0;
        host_rdata_o = '0;
        if (rst_ni) begin
            cpu_rdata_o  = mem_rdata_i;
            host_rdata_o = mem_rdata_i;
            host_gnt_o   = host_win;
            cpu_stall_o  = stall_raw;
            if (host_win) begin
                mem_en_o    = 1'b1;
                mem_we_o    = host_we_i;
                mem_addr_o  = host_addr_i;
                mem_wdata_o = host_wdata_i;
            end else if (cpu_win) begin
                mem_en_o    = 1'b1;
                mem_we_o    = cpu_mem_write_en_i;
                mem_addr_o  = cpu_addr_i;
                mem_wdata_o = cpu_wdata_i;
            end
        end
    end

    assign cpu_rvalid_o  = (rsp_owner_q == OWN_CPU);
    assign host_rvalid_o = (rsp_owner_q == OWN_HOST);

    sat_counter #(
        .WIDTH   (STARVE_W),
        .MAX_VAL (STARVE_MAX)
    ) u_starve_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (host_win | ~host_req_i),
        .inc_i   (host_req_i & cpu_win),
        .count_o (starve_cnt)
    );

    sat_counter #(
        .WIDTH   (STALL_CNT_WIDTH)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (1'b0),
        .inc_i   (cpu_stall_o),
        .count_o (stall_count_o)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle expectations and read-data
// expectations are queued by the driver and checked by an independent monitor.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [7:0]  cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_stall, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        host_req = 1'b0, host_we = 1'b0;
    logic [7:0]  host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic        host_gnt, host_rvalid;
    logic [15:0] host_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic [15:0] stall_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        logic        gnt, stall, en, we;
        logic [7:0]  addr;
        logic [15:0] wd;
        logic        crv, hrv;
        logic [15:0] scnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] cpu_q[$];
    logic [15:0] host_q[$];

    always #5 clk = ~clk;

    dmem_arbiter #(
        .PROC_DATA_WIDTH (16),
        .DMEM_ADDR_WIDTH (8),
        .HOST_STARVE_MAX (4),
        .STALL_CNT_WIDTH (16)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .cpu_mem_read_en_i  (cpu_rd),
        .cpu_mem_write_en_i (cpu_wr),
        .cpu_addr_i         (cpu_addr),
        .cpu_wdata_i        (cpu_wdata),
        .cpu_stall_o        (cpu_stall),
        .cpu_rdata_o        (cpu_rdata),
        .cpu_rvalid_o       (cpu_rvalid),
        .host_req_i         (host_req),
        .host_we_i          (host_we),
        .host_addr_i        (host_addr),
        .host_wdata_i       (host_wdata),
        .host_gnt_o         (host_gnt),
        .host_rdata_o       (host_rdata),
        .host_rvalid_o      (host_rvalid),
        .mem_en_o           (mem_en),
        .mem_we_o           (mem_we),
        .mem_addr_o         (mem_addr),
        .mem_wdata_o        (mem_wdata),
        .mem_rdata_i        (mem_rdata),
        .stall_count_o      (stall_count)
    );

    // Synchronous single-port memory, one-cycle read latency.
    logic [15:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        mem[8'h10] = 16'hBEEF;
        mem[8'h01] = 16'h1111;
        mem[8'h02] = 16'h2222;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic exp_cpu(input logic [15:0] d);
        cpu_q.push_back(d);
    endtask

    task automatic exp_host(input logic [15:0] d);
        host_q.push_back(d);
    endtask

    task automatic cyc(
        input logic r,
        input logic c_rd, c_wr, input logic [7:0] c_a, input logic [15:0] c_d,
        input logic h_rq, h_we, input logic [7:0] h_a, input logic [15:0] h_d,
        input logic gnt, stall, en, we, input logic [7:0] a, input logic [15:0] wd,
        input logic crv, hrv, input logic [15:0] scnt
    );
        exp_t e;
        @(negedge clk);
        rst_ni     = r;
        cpu_rd     = c_rd;
        cpu_wr     = c_wr;
        cpu_addr   = c_a;
        cpu_wdata  = c_d;
        host_req   = h_rq;
        host_we    = h_we;
        host_addr  = h_a;
        host_wdata = h_d;
        e.gnt = gnt; e.stall = stall; e.en = en; e.we = we;
        e.addr = a; e.wd = wd; e.crv = crv; e.hrv = hrv; e.scnt = scnt;
        exp_q.push_back(e);
    endtask

    // Monitor: samples 4 time units after the negedge, well before the next posedge.
    initial begin
        exp_t        e;
        logic [15:0] d;
        forever begin
            @(negedge clk);
            #4;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("host_gnt",    32'(host_gnt),    32'(e.gnt));
                chk("cpu_stall",   32'(cpu_stall),   32'(e.stall));
                chk("mem_en",      32'(mem_en),      32'(e.en));
                chk("mem_we",      32'(mem_we),      32'(e.we));
                chk("cpu_rvalid",  32'(cpu_rvalid),  32'(e.crv));
                chk("host_rvalid", 32'(host_rvalid), 32'(e.hrv));
                chk("stall_count", 32'(stall_count), 32'(e.scnt));
                if (e.en) chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                if (e.en && e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.wd));
            end
            if (cpu_rvalid) begin
                if (cpu_q.size() == 0) begin
                    chk("cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'(0));
                end else begin
                    d = cpu_q.pop_front();
                    chk("cpu_rdata", 32'(cpu_rdata), 32'(d));
                end
            end
            if (host_rvalid) begin
                if (host_q.size() == 0) begin
                    chk("host_rvalid_unexpected", 32'(host_rvalid), 32'(0));
                end else begin
                    d = host_q.pop_front();
                    chk("host_rdata", 32'(host_rdata), 32'(d));
                end
            end
        end
    end

    initial begin
        // Reset held with active inputs: all outputs forced low.
        cyc(0, 1,0,8'h10,16'h0,   1,0,8'h20,16'h0,    0,0,0,0,8'h00,16'h0,    0,0,16'd0);
        cyc(1, 0,0,8'h00,16'h0,   0,0,8'h00,16'h0,    0,0,0,0,8'h00,16'h0,    0,0,16'd0);
        // CPU load from 0x10
        exp_cpu(16'hBEEF);
        cyc(1, 1,0,8'h10,16'h0,   0,0,8'h00,16'h0,    0,0,1,0,8'h10,16'h0,    0,0,16'd0);
        cyc(1, 0,0,8'h00,16'h0,   0,0,8'h00,16'h0,    0,0,0,0,8'h00,16'h0,    1,0,16'd0);
        // Host write with CPU idle
        cyc(1, 0,0,8'h00,16'h0,   1,1,8'h20,16'h1234, 1,0,1,1,8'h20,16'h1234, 0,0,16'd0);
        cyc(1, 0,0,8'h00,16'h0,   0,0,8'h00,16'h0,    0,0,0,0,8'h00,16'h0,    0,0,16'd0);
        // Continuous CPU loads, host read held: host loses 4 cycles, forced on the 5th
        exp_cpu(16'hBEEF);
        cyc(1, 1,0,8'h10,16'h0,   1,0,8'h20,16'h0,    0,0,1,0,8'h10,16'h0,    0,0,16'd0);
        for (int k = 0; k < 3; k++) begin
            exp_cpu(16'hBEEF);
            cyc(1, 1,0,8'h10,16'h0, 1,0,8'h20,16'h0,  0,0,1,0,8'h10,16'h0,    1,0,16'd0);
        end
        exp_host(16'h1234);
        cyc(1, 1,0,8'h10,16'h0,   1,0,8'h20,16'h0,    1,1,1,0,8'h20,16'h0,    1,0,16'd0);
        exp_cpu(16'hBEEF);
        cyc(1, 1,0,8'h10,16'h0,   0,0,8'h00,16'h0,    0,0,1,0,8'h10,16'h0,    0,1,16'd1);
        cyc(1, 0,0,8'h00,16'h0,   0,0,8'h00,16'h0,    0,0,0,0,8'h00,16'h0,    1,0,16'd1);
        // Alternating CPU read 0x01 / host read 0x02
        exp_cpu(16'h1111);
        cyc(1, 1,0,8'h01,16'h0,   0,0,8'h00,16'h0,    0,0,1,0,8'h01,16'h0,    0,0,16'd1);
        exp_host(16'h2222);
        cyc(1, 0,0,8'h00,16'h0,   1,0,8'h02,16'h0,    1,0,1,0,8'h02,16'h0,    1,0,16'd1);
        exp_cpu(16'h1111);
        cyc(1, 1,0,8'h01,16'h0,   0,0,8'h00,16'h0,    0,0,1,0,8'h01,16'h0,    0,1,16'd1);
        exp_host(16'h2222);
        cyc(1, 0,0,8'h00,16'h0,   1,0,8'h02,16'h0,    1,0,1,0,8'h02,16'h0,    1,0,16'd1);
        cyc(1, 0,0,8'h00,16'h0,   0,0,8'h00,16'h0,    0,0,0,0,8'h00,16'h0,    0,1,16'd1);
        // Read and write together: treated as a write, no response
        cyc(1, 1,1,8'h30,16'h5A5A, 0,0,8'h00,16'h0,   0,0,1,1,8'h30,16'h5A5A, 0,0,16'd1);
        cyc(1, 0,0,8'h00,16'h0,   0,0,8'h00,16'h0,    0,0,0,0,8'h00,16'h0,    0,0,16'd1);
        exp_cpu(16'h5A5A);
        cyc(1, 1,0,8'h30,16'h0,   0,0,8'h00,16'h0,    0,0,1,0,8'h30,16'h0,    0,0,16'd1);
        cyc(1, 0,0,8'h00,16'h0,   0,0,8'h00,16'h0,    0,0,0,0,8'h00,16'h0,    1,0,16'd1);
        // Reset the cycle after a CPU read: response dropped, state cleared
        cyc(1, 1,0,8'h10,16'h0,   0,0,8'h00,16'h0,    0,0,1,0,8'h10,16'h0,    0,0,16'd1);
        cyc(0, 1,0,8'h10,16'h0,   1,0,8'h02,16'h0,    0,0,0,0,8'h00,16'h0,    0,0,16'd0);
        cyc(0, 0,0,8'h00,16'h0,   0,0,8'h00,16'h0,    0,0,0,0,8'h00,16'h0,    0,0,16'd0);
        cyc(1, 0,0,8'h00,16'h0,   0,0,8'h00,16'h0,    0,0,0,0,8'h00,16'h0,    0,0,16'd0);
        exp_cpu(16'hBEEF);
        cyc(1, 1,0,8'h10,16'h0,   0,0,8'h00,16'h0,    0,0,1,0,8'h10,16'h0,    0,0,16'd0);
        cyc(1, 0,0,8'h00,16'h0,   0,0,8'h00,16'h0,    0,0,0,0,8'h00,16'h0,    1,0,16'd0);
        // Host loses once, then wins as soon as the CPU goes idle
        exp_cpu(16'hBEEF);
        cyc(1, 1,0,8'h10,16'h0,   1,0,8'h02,16'h0,    0,0,1,0,8'h10,16'h0,    0,0,16'd0);
        exp_host(16'h2222);
        cyc(1, 0,0,8'h00,16'h0,   1,0,8'h02,16'h0,    1,0,1,0,8'h02,16'h0,    1,0,16'd0);
        cyc(1, 0,0,8'h00,16'h0,   0,0,8'h00,16'h0,    0,0,0,0,8'h00,16'h0,    0,1,16'd0);
        cyc(1, 0,0,8'h00,16'h0,   0,0,8'h00,16'h0,    0,0,0,0,8'h00,16'h0,    0,0,16'd0);

        // Bounded drain of the expectation queues
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("exp_queue_drained",  32'(exp_q.size()),  32'(0));
        chk("cpu_rsp_outstanding",  32'(cpu_q.size()),  32'(0));
        chk("host_rsp_outstanding", 32'(host_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
